// File: rtl/alu_wb_buffer_pkg.sv
// rtl/alu_wb_buffer_pkg.sv - shared widths and entry type for the ALU writeback result buffer
package alu_wb_buffer_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned TRANS_ID_BITS = 4;

    typedef logic [XLEN-1:0] xlen_t;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        xlen_t                    result;
    } alu_wb_entry_t;

endpackage

// File: rtl/alu_wb_buffer_if.sv
// rtl/alu_wb_buffer_if.sv - ALU-side and writeback-side handshake bundle for alu_wb_buffer
interface alu_wb_buffer_if;
    import alu_wb_buffer_pkg::*;

    logic                     alu_valid_i;
    logic                     alu_ready_o;
    logic [TRANS_ID_BITS-1:0] alu_trans_id_i;
    xlen_t                    alu_result_i;
    logic                     wb_valid_o;
    logic                     wb_ready_i;
    logic [TRANS_ID_BITS-1:0] wb_trans_id_o;
    xlen_t                    wb_result_o;

    // Environment side: drives ALU results in and writeback ready.
    modport master (
        output alu_valid_i, alu_trans_id_i, alu_result_i, wb_ready_i,
        input  alu_ready_o, wb_valid_o, wb_trans_id_o, wb_result_o
    );

    modport slave (
        input  alu_valid_i, alu_trans_id_i, alu_result_i, wb_ready_i,
        output alu_ready_o, wb_valid_o, wb_trans_id_o, wb_result_o
    );

endinterface

// File: rtl/alu_wb_buffer.sv
// rtl/alu_wb_buffer.sv - FIFO of ALU results presented to the writeback port via valid/ready
module alu_wb_buffer
    import alu_wb_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    alu_wb_buffer_if.slave           bus,
    output logic [$clog2(DEPTH):0]   usage_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    alu_wb_entry_t    mem_q [DEPTH];
    alu_wb_entry_t    mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    // Ready looks only at count_q, so a pop never reopens the slot in the same cycle.
    assign bus.alu_ready_o   = (count_q < FULL);
    assign bus.wb_valid_o    = (count_q != '0);
    assign bus.wb_trans_id_o = mem_q[rd_ptr_q].trans_id;
    assign bus.wb_result_o   = mem_q[rd_ptr_q].result;
    assign usage_o           = count_q;

    assign push = bus.alu_valid_i & bus.alu_ready_o & ~flush_i;
    assign pop  = bus.wb_valid_o  & bus.wb_ready_i  & ~flush_i;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{trans_id: bus.alu_trans_id_i, result: bus.alu_result_i};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (count_q == FULL) |-> !push);

    a_head_stable_on_stall: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.wb_valid_o && !bus.wb_ready_i && !flush_i)
        |=> ($stable(bus.wb_trans_id_o) && $stable(bus.wb_result_o)));

    a_usage_bounded: assert property (@(posedge clk_i) disable iff (!rst_ni)
        usage_o <= FULL);

endmodule

// File: tb/tb_alu_wb_buffer.sv
// tb/tb_alu_wb_buffer.sv - directed and randomized checks of alu_wb_buffer against a queue model
module tb_alu_wb_buffer;
    import alu_wb_buffer_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic                   flush_i;
    logic [$clog2(DEPTH):0] usage_o;

    alu_wb_buffer_if bus ();

    alu_wb_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .bus     (bus),
        .usage_o (usage_o)
    );

    always #5 clk_i = ~clk_i;

    int            checks = 0;
    int            errors = 0;
    alu_wb_entry_t model_q[$];
    int            delivered[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        int n;
        n = model_q.size();
        chk({tag, "_ready"}, 64'(bus.alu_ready_o), 64'(n < DEPTH));
        chk({tag, "_valid"}, 64'(bus.wb_valid_o), 64'(n != 0));
        chk({tag, "_usage"}, 64'(usage_o), 64'(n));
        if (n != 0) begin
            chk({tag, "_id"}, 64'(bus.wb_trans_id_o), 64'(model_q[0].trans_id));
            chk({tag, "_result"}, bus.wb_result_o, model_q[0].result);
        end
    endtask

    task automatic drive(input logic v, input int id, input logic [63:0] res,
                         input logic rdy, input logic fl);
        bus.alu_valid_i    = v;
        bus.alu_trans_id_i = TRANS_ID_BITS'(id);
        bus.alu_result_i   = res;
        bus.wb_ready_i     = rdy;
        flush_i            = fl;
    endtask

    // Check current outputs, advance the queue model by the rules, then take one clock.
    task automatic cycle(input string tag);
        int n;
        bit do_push, do_pop;
        check_outputs(tag);
        if (bus.wb_valid_o && bus.wb_ready_i && !flush_i)
            delivered.push_back(int'(bus.wb_trans_id_o));
        n       = model_q.size();
        do_push = bus.alu_valid_i && (n < DEPTH) && !flush_i;
        do_pop  = (n != 0) && bus.wb_ready_i && !flush_i;
        if (flush_i) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back('{trans_id: bus.alu_trans_id_i, result: bus.alu_result_i});
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        drive(1'b0, 0, 64'h0, 1'b0, 1'b0);
        #3;
        chk("reset_valid", 64'(bus.wb_valid_o), 64'd0);
        chk("reset_usage", 64'(usage_o), 64'd0);
        chk("reset_ready", 64'(bus.alu_ready_o), 64'd1);
        chk("reset_id", 64'(bus.wb_trans_id_o), 64'd0);
        chk("reset_result", bus.wb_result_o, 64'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        drive(1'b1, 3, 64'hDEAD_BEEF, 1'b1, 1'b0);
        cycle("single_push");
        drive(1'b0, 0, 64'h0, 1'b1, 1'b0);
        chk("single_valid", 64'(bus.wb_valid_o), 64'd1);
        chk("single_id", 64'(bus.wb_trans_id_o), 64'd3);
        chk("single_result", bus.wb_result_o, 64'hDEAD_BEEF);
        cycle("single_pop");
        chk("single_empty_valid", 64'(bus.wb_valid_o), 64'd0);
        chk("single_empty_usage", 64'(usage_o), 64'd0);

        drive(1'b1, 1, 64'h1111, 1'b0, 1'b0);
        cycle("bp_push1");
        drive(1'b1, 2, 64'h2222, 1'b0, 1'b0);
        cycle("bp_push2");
        drive(1'b0, 0, 64'h0, 1'b0, 1'b0);
        chk("bp_usage", 64'(usage_o), 64'd2);
        chk("bp_ready", 64'(bus.alu_ready_o), 64'd0);
        chk("bp_head", 64'(bus.wb_trans_id_o), 64'd1);
        cycle("bp_hold");
        chk("bp_head_held", 64'(bus.wb_trans_id_o), 64'd1);
        delivered.delete();
        drive(1'b0, 0, 64'h0, 1'b1, 1'b0);
        cycle("bp_rel1");
        cycle("bp_rel2");
        chk("bp_count", 64'(delivered.size()), 64'd2);
        for (int i = 0; i < delivered.size(); i++)
            chk("bp_order", 64'(delivered[i]), 64'(i + 1));

        drive(1'b1, 4, 64'h4444, 1'b0, 1'b0);
        cycle("full_fill1");
        drive(1'b1, 5, 64'h5555, 1'b0, 1'b0);
        cycle("full_fill2");
        drive(1'b1, 6, 64'h6666, 1'b1, 1'b0);
        chk("full_pop_ready", 64'(bus.alu_ready_o), 64'd0);
        cycle("full_pop");
        drive(1'b0, 0, 64'h0, 1'b0, 1'b0);
        chk("full_after_ready", 64'(bus.alu_ready_o), 64'd1);
        chk("full_after_usage", 64'(usage_o), 64'd1);
        chk("full_after_head", 64'(bus.wb_trans_id_o), 64'd5);
        drive(1'b0, 0, 64'h0, 1'b1, 1'b0);
        cycle("full_drain");

        delivered.delete();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, i, {32'hC0DE_0000, 32'(i)}, 1'b1, 1'b0);
            if (i > 0) chk("stream_usage", 64'(usage_o), 64'd1);
            cycle("stream");
        end
        drive(1'b0, 0, 64'h0, 1'b1, 1'b0);
        cycle("stream_tail");
        chk("stream_count", 64'(delivered.size()), 64'd10);
        for (int i = 0; i < delivered.size(); i++)
            chk("stream_order", 64'(delivered[i]), 64'(i));

        drive(1'b1, 7, 64'h7777, 1'b0, 1'b0);
        cycle("flush_fill1");
        drive(1'b1, 8, 64'h8888, 1'b0, 1'b0);
        cycle("flush_fill2");
        drive(1'b1, 9, 64'h9999, 1'b1, 1'b1);
        cycle("flush");
        drive(1'b0, 0, 64'h0, 1'b1, 1'b0);
        chk("flush_valid", 64'(bus.wb_valid_o), 64'd0);
        chk("flush_usage", 64'(usage_o), 64'd0);
        chk("flush_ready", 64'(bus.alu_ready_o), 64'd1);
        cycle("flush_after");
        chk("flush_dropped", 64'(bus.wb_valid_o), 64'd0);

        drive(1'b1, 10, 64'hAAAA_5555, 1'b0, 1'b0);
        cycle("rst_push");
        drive(1'b0, 0, 64'h0, 1'b0, 1'b0);
        chk("rst_pre_usage", 64'(usage_o), 64'd1);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("rst_async_valid", 64'(bus.wb_valid_o), 64'd0);
        chk("rst_async_usage", 64'(usage_o), 64'd0);
        chk("rst_async_result", bus.wb_result_o, 64'd0);
        chk("rst_async_id", 64'(bus.wb_trans_id_o), 64'd0);
        model_q.delete();
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
                  {$urandom, $urandom}, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 29) == 0);
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
